// File: rtl/hsv2rgb_pipe.sv
// ----------------------------------------------------------------------------
// hsv2rgb_pipe
//
// Converts a 24-bit HSV pixel stream (H = degrees/2 in 0..179, S and V in
// 0..255) back to 24-bit RGB. This is the inverse of the colour path's
// RGB-to-HSV stage. It sits after HSV-domain filtering so processed pixels
// can be shown on the RGB video output.
//
// The datapath is fully pipelined: one pixel per clock and a fixed latency of
// LATENCY (4) pclk cycles. There is no backpressure and no stall.
//
// Handshake: valid-only streaming. valid_in marks HSV24 as a real pixel on
// that pclk edge. Bubbles (valid_in=0) still travel down the pipe with
// don't-care data, and they emerge with valid_out=0. The sync_in qualifiers
// travel with every slot, valid or not. There is no ready signal, so the
// consumer must accept a pixel on every cycle where valid_out=1.
//
// Ports:
//   pclk      in   1   pixel clock; all logic on the rising edge
//   rst       in   1   synchronous active-high reset; clears every register
//   valid_in  in   1   HSV24 holds a valid pixel this cycle
//   sync_in   in   3   {vsync, hsync, de}, carried alongside the pixel
//   HSV24     in  24   [23:16] H (degrees/2), [15:8] S, [7:0] V
//   valid_out out  1   RGB24 is valid
//   sync_out  out  3   sync_in delayed by LATENCY cycles
//   RGB24     out 24   [23:16] R, [15:8] G, [7:0] B
// ----------------------------------------------------------------------------
module hsv2rgb_pipe #(
    parameter int LATENCY = 4  // fixed pipeline depth; 4 is the only legal value
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [2:0]  sync_in,
    input  logic [23:0] HSV24,
    output logic        valid_out,
    output logic [2:0]  sync_out,
    output logic [23:0] RGB24
);

    // ------------------------------------------------------------------
    // Qualifier delay line: {valid, sync} shifted alongside the data.
    // ------------------------------------------------------------------
    logic [3:0] qual_pipe [LATENCY];

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                qual_pipe[i] <= '0;
            end
        end else begin
            qual_pipe[0] <= {valid_in, sync_in};
            for (int i = 1; i < LATENCY; i++) begin
                qual_pipe[i] <= qual_pipe[i-1];
            end
        end
    end

    assign valid_out = qual_pipe[LATENCY-1][3];
    assign sync_out  = qual_pipe[LATENCY-1][2:0];

    // ------------------------------------------------------------------
    // Stage 1: hue wrap, then split into sector (Hw/30) and fraction
    // (Hw mod 30).
    // ------------------------------------------------------------------
    logic [7:0] h_in;
    logic [7:0] hw_c;
    logic [7:0] base_c;
    logic [2:0] sec_c;
    logic [4:0] f_c;

    assign h_in = HSV24[23:16];
    // Out-of-range hues (180..255) fold back into 0..75, so the sector
    // always lands in 0..5.
    assign hw_c = (h_in >= 8'd180) ? (h_in - 8'd180) : h_in;

    always_comb begin
        sec_c  = 3'd0;
        base_c = 8'd0;
        if (hw_c >= 8'd150) begin
            sec_c  = 3'd5;
            base_c = 8'd150;
        end else if (hw_c >= 8'd120) begin
            sec_c  = 3'd4;
            base_c = 8'd120;
        end else if (hw_c >= 8'd90) begin
            sec_c  = 3'd3;
            base_c = 8'd90;
        end else if (hw_c >= 8'd60) begin
            sec_c  = 3'd2;
            base_c = 8'd60;
        end else if (hw_c >= 8'd30) begin
            sec_c  = 3'd1;
            base_c = 8'd30;
        end
        // The difference is always 0..29, so five bits hold it exactly.
        f_c = 5'(hw_c - base_c);
    end

    logic [7:0] s1_s;
    logic [7:0] s1_v;
    logic [2:0] s1_sec;
    logic [4:0] s1_f;

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_s   <= '0;
            s1_v   <= '0;
            s1_sec <= '0;
            s1_f   <= '0;
        end else begin
            s1_s   <= HSV24[15:8];
            s1_v   <= HSV24[7:0];
            s1_sec <= sec_c;
            s1_f   <= f_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: products. With 7650 = 255*30, q and t come out exactly
    // scaled, and no fraction has to be kept below integer resolution.
    //   kp = 255 - S, kq = 7650 - S*f, kt = 7650 - S*(30-f)
    // S*f <= 255*29 and S*(30-f) <= 7650, so neither subtraction can go
    // negative and 13 bits are enough.
    // ------------------------------------------------------------------
    logic [7:0]  kp_c;
    logic [12:0] sf_c;
    logic [4:0]  omf_c;
    logic [12:0] somf_c;
    logic [12:0] kq_c;
    logic [12:0] kt_c;

    assign kp_c   = 8'd255 - s1_s;
    assign sf_c   = {5'd0, s1_s} * {8'd0, s1_f};
    assign omf_c  = 5'd30 - s1_f;
    assign somf_c = {5'd0, s1_s} * {8'd0, omf_c};
    assign kq_c   = 13'd7650 - sf_c;
    assign kt_c   = 13'd7650 - somf_c;

    logic [15:0] s2_vkp;
    logic [20:0] s2_vkq;
    logic [20:0] s2_vkt;
    logic [7:0]  s2_v;
    logic [2:0]  s2_sec;

    always_ff @(posedge pclk) begin
        if (rst) begin
            s2_vkp <= '0;
            s2_vkq <= '0;
            s2_vkt <= '0;
            s2_v   <= '0;
            s2_sec <= '0;
        end else begin
            s2_vkp <= {8'd0, s1_v} * {8'd0, kp_c};
            s2_vkq <= {13'd0, s1_v} * {8'd0, kq_c};
            s2_vkt <= {13'd0, s1_v} * {8'd0, kt_c};
            s2_v   <= s1_v;
            s2_sec <= s1_sec;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: truncating division by constants. Each quotient is <= V,
    // so it fits in 8 bits.
    // ------------------------------------------------------------------
    logic [7:0] s3_p;
    logic [7:0] s3_q;
    logic [7:0] s3_t;
    logic [7:0] s3_v;
    logic [2:0] s3_sec;

    always_ff @(posedge pclk) begin
        if (rst) begin
            s3_p   <= '0;
            s3_q   <= '0;
            s3_t   <= '0;
            s3_v   <= '0;
            s3_sec <= '0;
        end else begin
            s3_p   <= 8'(s2_vkp / 16'd255);
            s3_q   <= 8'(s2_vkq / 21'd7650);
            s3_t   <= 8'(s2_vkt / 21'd7650);
            s3_v   <= s2_v;
            s3_sec <= s2_sec;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: sector select into the output register.
    // ------------------------------------------------------------------
    logic [23:0] rgb_c;

    always_comb begin
        rgb_c = {s3_v, s3_t, s3_p};
        case (s3_sec)
            3'd0:    rgb_c = {s3_v, s3_t, s3_p};
            3'd1:    rgb_c = {s3_q, s3_v, s3_p};
            3'd2:    rgb_c = {s3_p, s3_v, s3_t};
            3'd3:    rgb_c = {s3_p, s3_q, s3_v};
            3'd4:    rgb_c = {s3_t, s3_p, s3_v};
            3'd5:    rgb_c = {s3_v, s3_p, s3_q};
            default: rgb_c = {s3_v, s3_t, s3_p};
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            RGB24 <= '0;
        end else begin
            RGB24 <= rgb_c;
        end
    end

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// ----------------------------------------------------------------------------
// tb_hsv2rgb_pipe
//
// Directed vectors with hand-computed RGB results. Each driven pixel pushes
// its expected colour, sync value and issue cycle into queues. A negedge
// monitor pops an entry whenever valid_out is high, and it checks the colour,
// the sync and the 4-cycle latency. A per-cycle schedule also fixes the
// expected valid_out and sync_out for every slot, including bubbles and the
// zeroed cycles that follow a reset.
// ----------------------------------------------------------------------------
module tb_hsv2rgb_pipe;

    logic        pclk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  sync_in;
    logic [23:0] HSV24;
    logic        valid_out;
    logic [2:0]  sync_out;
    logic [23:0] RGB24;

    hsv2rgb_pipe #(.LATENCY(4)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sync_in   (sync_in),
        .HSV24     (HSV24),
        .valid_out (valid_out),
        .sync_out  (sync_out),
        .RGB24     (RGB24)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];
    logic [2:0]  exp_sync_q[$];
    int          exp_cyc_q[$];

    bit       sched_known [0:2047];
    bit       sched_valid [0:2047];
    bit [2:0] sched_sync  [0:2047];
    bit       sched_zero  [0:2047];

    int checks = 0;
    int errors = 0;

    // ---------------- driver tasks ----------------
    task automatic drive_px(input logic [7:0] h, input logic [7:0] s,
                            input logic [7:0] v, input logic [2:0] sy,
                            input logic [23:0] exp_rgb);
        valid_in = 1'b1;
        sync_in  = sy;
        HSV24    = {h, s, v};
        sched_known[cyc+4] = 1'b1;
        sched_valid[cyc+4] = 1'b1;
        sched_sync[cyc+4]  = sy;
        sched_zero[cyc+4]  = 1'b0;
        exp_q.push_back(exp_rgb);
        exp_sync_q.push_back(sy);
        exp_cyc_q.push_back(cyc);
        @(posedge pclk); #1;
    endtask

    task automatic drive_idle(input logic [2:0] sy);
        valid_in = 1'b0;
        sync_in  = sy;
        HSV24    = 24'($urandom_range(0, 24'hFFFFFF));
        sched_known[cyc+4] = 1'b1;
        sched_valid[cyc+4] = 1'b0;
        sched_sync[cyc+4]  = sy;
        sched_zero[cyc+4]  = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Holds rst for n edges. Pixels that would leave the pipe at or after the
    // first reset edge are dropped from the expectations. The outputs must
    // then read zero until the first pixel driven after reset arrives.
    task automatic do_reset(input int n);
        int r;
        rst      = 1'b1;
        valid_in = 1'b0;
        sync_in  = 3'b000;
        HSV24    = 24'h0;
        r = cyc;
        while (exp_cyc_q.size() > 0 && exp_cyc_q[$] + 4 > r) begin
            void'(exp_q.pop_back());
            void'(exp_sync_q.pop_back());
            void'(exp_cyc_q.pop_back());
        end
        repeat (n) @(posedge pclk);
        #1;
        rst = 1'b0;
        for (int k = r + 1; k <= cyc + 3; k++) begin
            sched_known[k] = 1'b1;
            sched_valid[k] = 1'b0;
            sched_sync[k]  = 3'b000;
            sched_zero[k]  = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge pclk) begin
        if (sched_known[cyc]) begin
            checks++;
            if (valid_out !== sched_valid[cyc]) begin
                errors++;
                $display("FAIL valid_out cyc=%0d got=%b want=%b", cyc, valid_out, sched_valid[cyc]);
            end
            checks++;
            if (sync_out !== sched_sync[cyc]) begin
                errors++;
                $display("FAIL sync_out cyc=%0d got=%b want=%b", cyc, sync_out, sched_sync[cyc]);
            end
            if (sched_zero[cyc]) begin
                checks++;
                if (RGB24 !== 24'h0) begin
                    errors++;
                    $display("FAIL rgb_zero cyc=%0d got=%06h want=000000", cyc, RGB24);
                end
            end
        end
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel cyc=%0d got=%06h want=none", cyc, RGB24);
            end else begin
                logic [23:0] e_rgb;
                logic [2:0]  e_sync;
                int          e_cyc;
                e_rgb  = exp_q.pop_front();
                e_sync = exp_sync_q.pop_front();
                e_cyc  = exp_cyc_q.pop_front();
                checks++;
                if (RGB24 !== e_rgb) begin
                    errors++;
                    $display("FAIL rgb cyc=%0d got=%06h want=%06h", cyc, RGB24, e_rgb);
                end
                checks++;
                if (cyc != e_cyc + 4) begin
                    errors++;
                    $display("FAIL latency got=%0d want=4", cyc - e_cyc);
                end
                checks++;
                if (sync_out !== e_sync) begin
                    errors++;
                    $display("FAIL pixel_sync cyc=%0d got=%b want=%b", cyc, sync_out, e_sync);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        sync_in  = 3'b000;
        HSV24    = 24'h0;
        do_reset(3);

        // Primaries on consecutive cycles.
        drive_px(8'd0,   8'd255, 8'd255, 3'b001, 24'hFF0000);
        drive_px(8'd60,  8'd255, 8'd255, 3'b001, 24'h00FF00);
        drive_px(8'd120, 8'd255, 8'd255, 3'b001, 24'h0000FF);
        // Grey (S=0), black (V=0).
        drive_px(8'd45,  8'd0,   8'd128, 3'b001, 24'h808080);
        drive_px(8'h5A,  8'hFF,  8'h00,  3'b001, 24'h000000);
        // Floor in t, and hue wrap 200 -> 20.
        drive_px(8'd15,  8'd255, 8'd255, 3'b001, 24'hFF7F00);
        drive_px(8'd200, 8'd255, 8'd255, 3'b001, 24'hFFAA00);
        // Secondaries at sector starts.
        drive_px(8'd30,  8'd255, 8'd255, 3'b001, 24'hFFFF00);
        drive_px(8'd90,  8'd255, 8'd255, 3'b001, 24'h00FFFF);
        drive_px(8'd150, 8'd255, 8'd255, 3'b001, 24'hFF00FF);
        // Mid-saturation values across sectors 1, 3 and 5.
        drive_px(8'd40,  8'd200, 8'd255, 3'b001, 24'hBCFF37);
        drive_px(8'd100, 8'd128, 8'd200, 3'b001, 24'h63A6C8);
        drive_px(8'd170, 8'd100, 8'd50,  3'b001, 24'h321E24);
        // Top legal hue, and largest out-of-range hue (255 -> 75).
        drive_px(8'd179, 8'd255, 8'd255, 3'b001, 24'hFF0008);
        drive_px(8'd255, 8'd255, 8'd255, 3'b001, 24'h00FF7F);

        // Sync pattern with interleaved bubbles.
        drive_idle(3'b000);
        drive_px(8'd0,   8'd255, 8'd255, 3'b001, 24'hFF0000);
        drive_idle(3'b110);
        drive_px(8'd60,  8'd255, 8'd255, 3'b011, 24'h00FF00);
        drive_idle(3'b000);
        drive_idle(3'b010);
        drive_px(8'd120, 8'd255, 8'd255, 3'b100, 24'h0000FF);
        repeat (6) drive_idle(3'b000);

        // Mid-stream reset with three pixels still in flight.
        drive_px(8'd0,   8'd255, 8'd255, 3'b001, 24'hFF0000);
        drive_px(8'd30,  8'd255, 8'd255, 3'b011, 24'hFFFF00);
        drive_px(8'd60,  8'd255, 8'd255, 3'b101, 24'h00FF00);
        drive_px(8'd90,  8'd255, 8'd255, 3'b111, 24'h00FFFF);
        drive_px(8'd120, 8'd255, 8'd255, 3'b111, 24'h0000FF);
        drive_px(8'd150, 8'd255, 8'd255, 3'b111, 24'hFF00FF);
        do_reset(1);
        drive_px(8'd15,  8'd255, 8'd255, 3'b001, 24'hFF7F00);
        drive_px(8'd45,  8'd0,   8'd128, 3'b011, 24'h808080);
        repeat (8) drive_idle(3'b000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsv2rgb_pipe.md
Name: hsv2rgb_pipe

Overview:
- Converts a 24-bit HSV pixel stream back to 24-bit RGB.
- It is the inverse of the ball-tracking colour path's RGB-to-HSV stage.
- It uses the same HSV packing: H = hue degrees/2 (0..179), S = 0..255, V = 0..255.
- It is a fully pipelined, one-pixel-per-clock, fixed-latency datapath. It sits after HSV-domain filtering/thresholding, so processed or overlaid pixels can be shown on the RGB video output.
- Video valid/sync qualifiers are delayed to stay aligned with the pixel data.

Parameters:
- LATENCY, 4, pipeline depth in pclk cycles. Fixed; the only legal value is 4, and it is exposed for reference by integrators.

Ports:
- pclk  input  1  pixel clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  HSV24 is a valid pixel this cycle.
- sync_in  input  3  {vsync, hsync, de}; carried alongside the pixel.
- HSV24  input  24  [23:16] H (degrees/2), [15:8] S, [7:0] V.
- valid_out  output  1  RGB24 is valid.
- sync_out  output  3  sync_in delayed by LATENCY.
- RGB24  output  24  [23:16] R, [15:8] G, [7:0] B.

Behaviour:
- Clocking and reset: one clock (pclk). Reset is synchronous and active-high (rst).
  - While rst is high at a pclk edge, every pipeline register clears to 0. That includes RGB24, valid_out and sync_out.
  - In the cycle after rst deasserts, outputs stay 0 until real data propagates.
  - Asserting rst mid-stream discards all in-flight pixels; nothing partial emerges afterwards.
- Throughput: one pixel per cycle, with no backpressure and no stall.
  - Pixels with valid_in=0 still flow through the pipeline. Their data is don't-care, but valid_out must be 0 for them.
- Latency: a pixel sampled at edge N appears on RGB24/valid_out/sync_out after edge N+4. valid_in and sync_in are delayed by exactly 4 registers.
- Stage 1 (register and decode):
  - Hue wrap: Hw = H-180 if H >= 180, else H. Legal inputs never exceed 179; wrap is defined so the block is robust to out-of-range values.
  - Sector sec = Hw/30 (0..5).
  - Fraction f = Hw mod 30 (0..29).
  - Register S, V, sec and f.
- Stage 2 (products), all unsigned:
  - kp = 255 - S
  - kq = 7650 - S*f
  - kt = 7650 - S*(30-f)
  - Form V*kp (16 bits), V*kq and V*kt (21 bits; max 255*7650 = 1,950,750).
- Stage 3 (division, truncating / floor):
  - p = V*kp/255
  - q = V*kq/7650
  - t = V*kt/7650
  - Each result fits in 8 bits. Constant-divisor division may be implemented combinationally between registers.
- Stage 4 (sector select, registered into RGB24):
  - sec 0: (R,G,B) = (V,t,p)
  - sec 1: (q,V,p)
  - sec 2: (p,V,t)
  - sec 3: (p,q,V)
  - sec 4: (t,p,V)
  - sec 5: (V,p,q)
- Boundary conditions:
  - S=0: output R=G=B=V for any H.
  - V=0: output 0x000000.
  - f=0 with S=255: t=0 and q=V, giving exact primary/secondary colours.
  - No intermediate overflow is permitted; the widths above are the minimums.
- The pipeline has no internal state beyond its data registers. sec and f must be carried in step with their pixel.

Test Plan:
- Reset then stream H=0,S=255,V=255 with valid_in=1 at edge N -> RGB24=0xFF0000 and valid_out=1 after edge N+4; valid_out=0 at edges N+1..N+3.
- H=60,S=255,V=255 -> 0x00FF00. H=120,S=255,V=255 -> 0x0000FF. Applied on consecutive cycles -> outputs on consecutive cycles, same order.
- H=45,S=0,V=128 -> 0x808080. HSV24=0x5AFF00 (V=0) -> 0x000000.
- H=15,S=255,V=255 -> 0xFF7F00 (t = 255*3825/7650 = 127, floor). Out-of-range H=200,S=255,V=255 wraps to 20 -> 0xFFAA00.
- sync_in pattern 3'b001,3'b011,3'b100 on valid cycles with interleaved valid_in=0 bubbles -> identical sync_out pattern and valid_out gaps, shifted by exactly 4 cycles.
- Stream 6 pixels, assert rst for 1 cycle while 3 are in flight -> from the edge after rst onward, RGB24=0, sync_out=0 and valid_out=0 until new pixels arrive 4 cycles after rst deasserts. No pre-reset pixel ever appears.
